branch_target_buffer: RTL

//  Direct-mapped BTB with 2-bit saturating counters; predicts the next fetch PC for IF stage.

---
 rtl/branch_target_buffer.sv | 111 +++++++++++
 1 files changed

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit saturating counters.
// Predicts the next fetch PC in IF, flags mispredictions in EX, and keeps branch statistics.
module branch_target_buffer #(
    parameter int unsigned IDX_W = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [31:0] PC_IF,
    output logic [31:0] NPC_predicted_IF,
    output logic        pred_taken_IF,
    output logic [31:0] pred_target_IF,
    input  logic        br_type_EX,
    input  logic        br,
    input  logic [31:0] br_target,
    input  logic [31:0] PC_EX,
    input  logic        pred_taken_EX,
    input  logic [31:0] pred_target_EX,
    output logic        fail,
    output logic [31:0] br_cnt,
    output logic [31:0] miss_cnt
);

    localparam int unsigned ENTRIES = 2 ** IDX_W;
    localparam int unsigned TAG_W   = 30 - IDX_W;

    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [TAG_W-1:0]   tag_d    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];
    logic [31:0]        target_d [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];
    logic [1:0]         ctr_d    [ENTRIES];
    logic [31:0]        br_cnt_q, br_cnt_d;
    logic [31:0]        miss_cnt_q, miss_cnt_d;

    logic [IDX_W-1:0] if_idx, ex_idx;
    logic [TAG_W-1:0] if_tag, ex_tag;
    logic             if_hit, ex_hit, upd;
    logic             unused_pc_ex;

    assign if_idx = PC_IF[IDX_W+1:2];
    assign if_tag = PC_IF[31:IDX_W+2];
    assign ex_idx = PC_EX[IDX_W+1:2];
    assign ex_tag = PC_EX[31:IDX_W+2];
    assign unused_pc_ex = ^PC_EX[1:0];

    assign if_hit = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
    assign upd    = en && br_type_EX;

    // Lookup always sees the registered table, so a same-cycle update is not forwarded.
    always_comb begin
        pred_taken_IF    = if_hit && ctr_q[if_idx][1];
        pred_target_IF   = if_hit ? target_q[if_idx] : 32'h0;
        NPC_predicted_IF = pred_taken_IF ? target_q[if_idx] : PC_IF + 32'd4;
    end

    assign fail = br_type_EX && ((br != pred_taken_EX) ||
                                 (br && pred_taken_EX && (br_target != pred_target_EX)));

    always_comb begin
        valid_d    = valid_q;
        tag_d      = tag_q;
        target_d   = target_q;
        ctr_d      = ctr_q;
        br_cnt_d   = br_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (upd) begin
            br_cnt_d   = br_cnt_q + 32'd1;
            miss_cnt_d = miss_cnt_q + {31'd0, fail};
            if (ex_hit) begin
                if (br) begin
                    ctr_d[ex_idx]    = (ctr_q[ex_idx] == 2'b11) ? 2'b11 : ctr_q[ex_idx] + 2'b01;
                    target_d[ex_idx] = br_target;
                end else begin
                    ctr_d[ex_idx] = (ctr_q[ex_idx] == 2'b00) ? 2'b00 : ctr_q[ex_idx] - 2'b01;
                end
            end else if (br) begin
                valid_d[ex_idx]  = 1'b1;
                tag_d[ex_idx]    = ex_tag;
                target_d[ex_idx] = br_target;
                ctr_d[ex_idx]    = 2'b10;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= '0;
            br_cnt_q   <= '0;
            miss_cnt_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
        end else begin
            valid_q    <= valid_d;
            tag_q      <= tag_d;
            target_q   <= target_d;
            ctr_q      <= ctr_d;
            br_cnt_q   <= br_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign br_cnt   = br_cnt_q;
    assign miss_cnt = miss_cnt_q;

endmodule
